// File: rtl/conv1_lif_encoder.sv
// Spiking encoder behind conv1: unrolled TIME_STEP-deep LIF pipeline (tau = 2, hard reset)
// feeding a packer that writes PACK_PIX pixel spike vectors per spike-RAM word.
module conv1_lif_encoder #(
  parameter int IN_BITS   = 20,
  parameter int IN_SHIFT  = 0,
  parameter int TIME_STEP = 4,
  parameter int V_TH      = 256,
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32,
  parameter int CHNNLS    = 48,
  parameter int PACK_PIX  = 16,
  parameter int ADDR_BITS = 12
) (
  input  logic                          s_clk,
  input  logic                          s_rst,
  input  logic                          network_cal_done,
  input  logic [IN_BITS-1:0]            i_conv_data,
  input  logic                          i_conv_valid,
  output logic                          o_spike_wr_en,
  output logic [ADDR_BITS-1:0]          o_spike_wr_addr,
  output logic [PACK_PIX*TIME_STEP-1:0] o_spike_wr_data,
  output logic                          o_chnnl_done,
  output logic                          o_layer_done,
  output logic                          o_overflow,
  output logic [1:0]                    o_dbg_state
);

  localparam int XW     = IN_BITS + 2;
  localparam int DW     = PACK_PIX * TIME_STEP;
  localparam int WORDS  = IMG_W * IMG_H / PACK_PIX;
  localparam int PIX_W  = (PACK_PIX > 1) ? $clog2(PACK_PIX) : 1;
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CH_W   = (CHNNLS > 1) ? $clog2(CHNNLS) : 1;
  localparam logic signed [XW-1:0] L_TH = XW'(V_TH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;
  logic   w_accept, w_drop, w_clear;
  logic   r_final;

  // Input handshake: i_conv_valid alone qualifies i_conv_data on a rising s_clk edge;
  // there is no ready, so a valid seen in S_DONE is dropped and flagged in o_overflow.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_conv_valid) w_state_nxt = S_RUN;
      S_RUN:   if (r_final) w_state_nxt = S_DONE;
      S_DONE:  if (network_cal_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_layer_done = (r_state == S_DONE);
    o_dbg_state  = r_state;
    w_accept     = i_conv_valid && (r_state != S_DONE);
    w_drop       = i_conv_valid && (r_state == S_DONE);
    w_clear      = network_cal_done && (r_state == S_DONE);
  end

  logic signed [XW-1:0] w_x_ext, w_x_in;
  assign w_x_ext = {{2{i_conv_data[IN_BITS-1]}}, i_conv_data};
  assign w_x_in  = w_x_ext >>> IN_SHIFT;

  // Index 0 is the input register; index t+1 holds the result of LIF step t.
  logic signed [XW-1:0]  r_x   [0:TIME_STEP];
  logic signed [XW-1:0]  r_v   [0:TIME_STEP];
  logic [TIME_STEP-1:0]  r_spk [0:TIME_STEP];
  logic [TIME_STEP:0]    r_vld;
  logic signed [XW-1:0]  w_h   [0:TIME_STEP-1];
  logic [TIME_STEP-1:0]  w_fire;

  always_comb begin
    for (int t = 0; t < TIME_STEP; t++) begin
      w_h[t]    = r_v[t] + ((r_x[t] - r_v[t]) >>> 1);
      w_fire[t] = (w_h[t] >= L_TH);
    end
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      for (int i = 0; i <= TIME_STEP; i++) begin
        r_x[i]   <= '0;
        r_v[i]   <= '0;
        r_spk[i] <= '0;
      end
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_accept;
      r_x[0]   <= w_x_in;
      r_v[0]   <= '0;
      r_spk[0] <= '0;
      for (int t = 0; t < TIME_STEP; t++) begin
        r_vld[t+1] <= r_vld[t];
        r_x[t+1]   <= r_x[t];
        r_v[t+1]   <= w_fire[t] ? '0 : w_h[t];
        r_spk[t+1] <= r_spk[t] | (TIME_STEP'(w_fire[t]) << t);
      end
    end
  end

  logic [DW-1:0]        r_word, w_word;
  logic [PIX_W-1:0]     r_pix;
  logic [WIDX_W-1:0]    r_widx;
  logic [CH_W-1:0]      r_ch;
  logic [ADDR_BITS-1:0] r_base;
  logic                 w_out_vld, w_last_pix, w_last_word, w_last_ch;

  assign w_out_vld   = r_vld[TIME_STEP];
  assign w_last_pix  = (r_pix == PIX_W'(PACK_PIX - 1));
  assign w_last_word = (r_widx == WIDX_W'(WORDS - 1));
  assign w_last_ch   = (r_ch == CH_W'(CHNNLS - 1));

  always_comb begin
    w_word = r_word;
    w_word[r_pix*TIME_STEP +: TIME_STEP] = r_spk[TIME_STEP];
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_word          <= '0;
      r_pix           <= '0;
      r_widx          <= '0;
      r_ch            <= '0;
      r_base          <= '0;
      r_final         <= 1'b0;
      o_spike_wr_en   <= 1'b0;
      o_spike_wr_addr <= '0;
      o_spike_wr_data <= '0;
      o_chnnl_done    <= 1'b0;
    end else begin
      o_spike_wr_en <= 1'b0;
      o_chnnl_done  <= 1'b0;
      r_final       <= 1'b0;
      if (w_clear) begin
        r_word <= '0;
        r_pix  <= '0;
        r_widx <= '0;
        r_ch   <= '0;
        r_base <= '0;
      end else if (w_out_vld) begin
        if (w_last_pix) begin
          o_spike_wr_en   <= 1'b1;
          o_spike_wr_data <= w_word;
          o_spike_wr_addr <= r_base + ADDR_BITS'(r_widx);
          r_pix           <= '0;
          r_word          <= '0;
          if (w_last_word) begin
            r_widx       <= '0;
            o_chnnl_done <= 1'b1;
            if (w_last_ch) begin
              r_ch    <= '0;
              r_base  <= '0;
              r_final <= 1'b1;
            end else begin
              r_ch   <= r_ch + 1'b1;
              r_base <= r_base + ADDR_BITS'(WORDS);
            end
          end else begin
            r_widx <= r_widx + 1'b1;
          end
        end else begin
          r_pix  <= r_pix + 1'b1;
          r_word <= w_word;
        end
      end
    end
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst)        o_overflow <= 1'b0;
    else if (w_drop)  o_overflow <= 1'b1;
    else if (w_clear) o_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_conv1_lif_encoder.sv
// Bench for conv1_lif_encoder: table vectors, hand sequences and a randomized full layer
// checked against an arithmetic LIF model and a write scoreboard with expected cycles.
module tb_conv1_lif_encoder;

  localparam int IN_BITS = 20;
  localparam int TS      = 4;
  localparam int DW      = 64;
  localparam int AW      = 12;
  localparam int WORDS   = 64;
  localparam int CH      = 48;
  localparam int W       = 1 + AW + DW;

  logic                 s_clk = 1'b0;
  logic                 s_rst;
  logic                 network_cal_done;
  logic [IN_BITS-1:0]   i_conv_data;
  logic                 i_conv_valid;
  logic                 o_spike_wr_en;
  logic [AW-1:0]        o_spike_wr_addr;
  logic [DW-1:0]        o_spike_wr_data;
  logic                 o_chnnl_done;
  logic                 o_layer_done;
  logic                 o_overflow;
  logic [1:0]           o_dbg_state;

  conv1_lif_encoder dut (
    .s_clk            (s_clk),
    .s_rst            (s_rst),
    .network_cal_done (network_cal_done),
    .i_conv_data      (i_conv_data),
    .i_conv_valid     (i_conv_valid),
    .o_spike_wr_en    (o_spike_wr_en),
    .o_spike_wr_addr  (o_spike_wr_addr),
    .o_spike_wr_data  (o_spike_wr_data),
    .o_chnnl_done     (o_chnnl_done),
    .o_layer_done     (o_layer_done),
    .o_overflow       (o_overflow),
    .o_dbg_state      (o_dbg_state)
  );

  // clock / reset block
  always #5 s_clk = ~s_clk;
  int cyc = 0;
  always @(posedge s_clk) cyc <= cyc + 1;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // behavioural reference: LIF with floor(d/2) done in plain integer arithmetic
  function automatic logic [3:0] ref_nibble(int x);
    longint v, h, d;
    logic [3:0] nib;
    v = 0;
    nib = '0;
    for (int t = 0; t < TS; t++) begin
      d = longint'(x) - v;
      h = v + (((d < 0) && (d % 2 != 0)) ? (d / 2 - 1) : (d / 2));
      nib[t] = (h >= 256);
      v = nib[t] ? 0 : h;
    end
    return nib;
  endfunction

  function automatic int rand_x();
    case ($urandom_range(0, 9))
      0:       return 524287;
      1:       return -524288;
      default: return int'($urandom_range(0, 1400)) - 500;
    endcase
  endfunction

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           m_pix = 0;
  int           m_widx = 0;
  int           m_ch = 0;
  bit           m_done = 0;
  logic [DW-1:0] m_word = '0;
  bit           final_pending = 0;

  task automatic send_pix(int x, logic [3:0] nib);
    logic [AW-1:0] a;
    i_conv_valid = 1'b1;
    i_conv_data  = x[IN_BITS-1:0];
    m_word[m_pix*TS +: TS] = nib;
    if (m_pix == 15) begin
      a = AW'(m_ch * WORDS + m_widx);
      exp_q.push_back({(m_widx == WORDS - 1), a, m_word});
      exp_cyc_q.push_back(cyc + 6);
      m_pix  = 0;
      m_word = '0;
      if (m_widx == WORDS - 1) begin
        m_widx = 0;
        if (m_ch == CH - 1) begin
          m_ch   = 0;
          m_done = 1;
        end else m_ch++;
      end else m_widx++;
    end else m_pix++;
    @(posedge s_clk); #1;
  endtask

  task automatic idle(int n);
    i_conv_valid = 1'b0;
    repeat (n) begin @(posedge s_clk); #1; end
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    i_conv_valid = 1'b0;
    while (exp_q.size() > 0 && b < 50) begin
      @(posedge s_clk); #1;
      b++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d writes outstanding, required 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_wr_en"}, o_spike_wr_en, 0);
    check({tag, "_wr_addr"}, o_spike_wr_addr, 0);
    check({tag, "_wr_data"}, o_spike_wr_data, 0);
    check({tag, "_chnnl_done"}, o_chnnl_done, 0);
    check({tag, "_layer_done"}, o_layer_done, 0);
    check({tag, "_overflow"}, o_overflow, 0);
    check({tag, "_state"}, o_dbg_state, 0);
  endtask

  // write monitor, sampled on the falling edge
  always @(negedge s_clk) begin
    logic [W-1:0] e;
    int ec;
    if (final_pending) begin
      check("layer_done_rise", o_layer_done, 1);
      final_pending = 0;
    end
    if (o_spike_wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: addr %0d data %0h, required no write (cycle %0d)",
                 o_spike_wr_addr, o_spike_wr_data, cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("write_word", {o_chnnl_done, o_spike_wr_addr, o_spike_wr_data}, e);
        check("write_cycle", cyc, ec);
        if (e[W-1] && e[DW +: AW] == AW'(CH * WORDS - 1)) begin
          check("layer_done_low_at_final", o_layer_done, 0);
          final_pending = 1;
        end
      end
    end else if (o_chnnl_done) begin
      n_checks++;
      $display("FAIL stray_chnnl_done: chnnl_done 1 without write, required 0 (cycle %0d)", cyc);
    end
  end

  typedef struct {
    int         x;
    logic [3:0] nib;
  } vec_t;
  vec_t tbl[11];

  initial begin
    tbl[0]  = '{512,     4'hF};
    tbl[1]  = '{300,     4'h4};
    tbl[2]  = '{-100,    4'h0};
    tbl[3]  = '{256,     4'h0};
    tbl[4]  = '{1000,    4'hF};
    tbl[5]  = '{400,     4'hA};
    tbl[6]  = '{342,     4'hA};
    tbl[7]  = '{341,     4'h4};
    tbl[8]  = '{0,       4'h0};
    tbl[9]  = '{524287,  4'hF};
    tbl[10] = '{-524288, 4'h0};

    s_rst = 1'b1;
    network_cal_done = 1'b0;
    i_conv_valid = 1'b0;
    i_conv_data = '0;
    repeat (3) @(posedge s_clk);
    #1;
    check_all_zero("reset");
    s_rst = 1'b0;
    idle(2);

    // mid-stream reset: 14 pixels in flight are discarded
    for (int i = 0; i < 14; i++) send_pix(512, 4'hF);
    #2 s_rst = 1'b1;
    #1;
    check_all_zero("midreset");
    i_conv_valid = 1'b0;
    m_pix = 0;
    m_word = '0;
    @(posedge s_clk); #1;
    s_rst = 1'b0;
    idle(12);

    // table vectors: 16 identical pixels per word
    for (int i = 0; i < 11; i++)
      for (int p = 0; p < 16; p++) send_pix(tbl[i].x, tbl[i].nib);

    // alternating 300 / -100 gives 64'h0404_0404_0404_0404
    for (int p = 0; p < 16; p++) begin
      if (p % 2 == 0) send_pix(300, 4'h4);
      else            send_pix(-100, 4'h0);
    end
    wait_drain();

    // rest of channel 0 with random gaps; a cal_done pulse while running is ignored
    while (m_ch == 0) begin
      int x;
      x = rand_x();
      send_pix(x, ref_nibble(x));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if (m_widx == 30 && m_pix == 0) begin
        network_cal_done = 1'b1;
        idle(1);
        network_cal_done = 1'b0;
      end
    end
    check("run_layer_done_low", o_layer_done, 0);
    check("run_overflow_low", o_overflow, 0);
    check("run_state", o_dbg_state, 1);

    // remaining channels back-to-back
    while (!m_done) begin
      int x;
      x = rand_x();
      send_pix(x, ref_nibble(x));
    end
    wait_drain();
    idle(3);
    check("done_layer_done", o_layer_done, 1);
    check("done_overflow_clear", o_overflow, 0);
    check("done_state", o_dbg_state, 2);

    // input in S_DONE is dropped
    i_conv_valid = 1'b1;
    i_conv_data  = 20'd512;
    @(posedge s_clk); #1;
    idle(12);
    check("drop_overflow", o_overflow, 1);
    check("drop_layer_done_held", o_layer_done, 1);

    network_cal_done = 1'b1;
    @(posedge s_clk); #1;
    network_cal_done = 1'b0;
    check("cal_layer_done_fall", o_layer_done, 0);
    check("cal_overflow_clear", o_overflow, 0);
    check("cal_state_idle", o_dbg_state, 0);

    // next image starts again at address 0
    m_done = 0;
    for (int p = 0; p < 32; p++) send_pix(300, 4'h4);
    wait_drain();
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
